// File: rtl/clb_cfg_pkg.sv
// Shared types and constants for the CLB configuration chain controller.
// Holds the controller state encoding and the CRC-8 definition used on load and readback.
package clb_cfg_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StVerify,
        StCheck
    } cfg_state_e;

    localparam logic [7:0] Crc8Poly = 8'h07;
    localparam logic [7:0] Crc8Init = 8'h00;

    localparam int unsigned FrameBitsDefault = 17;

    // One bit-serial CRC-8 step, MSB-first register.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
        logic fb;
        fb = crc[7] ^ din;
        return {crc[6:0], 1'b0} ^ (fb ? Crc8Poly : 8'h00);
    endfunction

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 accumulator with synchronous clear.
// clear has priority over en; reset and clear both return to the init value.
module crc8_serial
    import clb_cfg_pkg::*;
(
    input  logic       prog_clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic [7:0] crc_q, crc_d;

    always_comb begin
        crc_d = crc_q;
        if (clear) begin
            crc_d = Crc8Init;
        end else if (en) begin
            crc_d = crc8_step(crc_q, bit_in);
        end
    end

    always_ff @(posedge prog_clk) begin
        if (!rst) begin
            crc_q <= Crc8Init;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/clb_cfg_ctrl.sv
// Loads a byte-wide bitstream serially into a daisy-chain of CLBs, then rotates the chain
// once through itself and compares the readback CRC-8 against the CRC of what was loaded.
module clb_cfg_ctrl
    import clb_cfg_pkg::*;
#(
    parameter int unsigned NUM_CLB    = 4,
    parameter int unsigned FRAME_BITS = FrameBitsDefault
) (
    input  logic       prog_clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] cfg_data,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic       chain_out,
    output logic       prog_in,
    output logic       prog_en,
    output logic       busy,
    output logic       done,
    output logic       pass
);

    localparam int unsigned CHAIN_LEN = NUM_CLB * FRAME_BITS;
    localparam int unsigned NBYTES    = (CHAIN_LEN + 7) / 8;
    localparam int unsigned LastBits  = ((CHAIN_LEN % 8) == 0) ? 8 : (CHAIN_LEN % 8);
    localparam int unsigned BitW      = $clog2(CHAIN_LEN + 1);
    localparam int unsigned ByteW     = $clog2(NBYTES + 1);

    localparam logic [BitW-1:0]  LastBitIdx   = BitW'(CHAIN_LEN - 1);
    localparam logic [ByteW-1:0] NumBytes     = ByteW'(NBYTES);
    localparam logic [ByteW-1:0] LastByteIdx  = ByteW'(NBYTES - 1);
    localparam logic [3:0]       LastByteBits = 4'(LastBits);

    cfg_state_e       state_q, state_d;
    logic [7:0]       buf_q, buf_d;
    logic [3:0]       buf_cnt_q, buf_cnt_d;
    logic [ByteW-1:0] byte_cnt_q, byte_cnt_d;
    logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
    logic             prog_en_q, prog_en_d;
    logic             prog_in_q, prog_in_d;
    logic             pass_q, pass_d;

    logic             crc_clear;
    logic             load_shift;
    logic             read_shift;
    logic             crc_match;
    logic [7:0]       crc_load;
    logic [7:0]       crc_read;

    assign load_shift = prog_en_q && (state_q == StLoad);
    assign read_shift = prog_en_q && (state_q == StVerify);
    assign crc_match  = (crc_read == crc_load);

    crc8_serial u_crc_load (
        .prog_clk (prog_clk),
        .rst      (rst),
        .clear    (crc_clear),
        .en       (load_shift),
        .bit_in   (prog_in_q),
        .crc      (crc_load)
    );

    crc8_serial u_crc_read (
        .prog_clk (prog_clk),
        .rst      (rst),
        .clear    (crc_clear),
        .en       (read_shift),
        .bit_in   (chain_out),
        .crc      (crc_read)
    );

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        buf_cnt_d  = buf_cnt_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        pass_d     = pass_q;
        prog_en_d  = 1'b0;
        prog_in_d  = 1'b0;
        crc_clear  = 1'b0;
        cfg_ready  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d    = StLoad;
                    crc_clear  = 1'b1;
                    pass_d     = 1'b0;
                    buf_cnt_d  = 4'd0;
                    byte_cnt_d = '0;
                    bit_cnt_d  = '0;
                end
            end

            StLoad: begin
                cfg_ready = (buf_cnt_q == 4'd0) && (byte_cnt_q < NumBytes);
                if (buf_cnt_q != 4'd0) begin
                    prog_en_d = 1'b1;
                    prog_in_d = buf_q[0];
                    buf_d     = {1'b0, buf_q[7:1]};
                    buf_cnt_d = buf_cnt_q - 4'd1;
                end else if (cfg_ready && cfg_valid) begin
                    buf_d      = cfg_data;
                    // Final byte carries only the bits that still fit in the chain.
                    buf_cnt_d  = (byte_cnt_q == LastByteIdx) ? LastByteBits : 4'd8;
                    byte_cnt_d = byte_cnt_q + 1'b1;
                end
                if (prog_en_q) begin
                    if (bit_cnt_q == LastBitIdx) begin
                        // Buffer is already drained here, so the load bit path idles.
                        state_d   = StVerify;
                        bit_cnt_d = '0;
                        prog_en_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                    end
                end
            end

            StVerify: begin
                if (bit_cnt_q == LastBitIdx) begin
                    state_d   = StCheck;
                    bit_cnt_d = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    prog_en_d = 1'b1;
                end
            end

            StCheck: begin
                pass_d  = crc_match;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_comb begin
        busy    = (state_q != StIdle);
        done    = (state_q == StCheck);
        pass    = done ? crc_match : pass_q;
        prog_en = prog_en_q;
        // During readback the chain feeds itself so its contents come back unchanged.
        prog_in = (state_q == StVerify) ? chain_out : prog_in_q;
    end

    always_ff @(posedge prog_clk) begin
        if (!rst) begin
            state_q    <= StIdle;
            buf_q      <= '0;
            buf_cnt_q  <= '0;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            prog_en_q  <= 1'b0;
            prog_in_q  <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            buf_cnt_q  <= buf_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            prog_en_q  <= prog_en_d;
            prog_in_q  <= prog_in_d;
            pass_q     <= pass_d;
        end
    end

endmodule
